// File: rtl/as_imem_loader_pkg.sv
// Shared types and defaults for the JTAG I-Mem load path (clk_i side).
package as_imem_loader_pkg;

   localparam int IM_ADDR_WIDTH  = 10;
   localparam int IM_INSTR_WIDTH = 32;
   localparam int IM_FIFO_DEPTH  = 4;
   localparam int IM_CNT_WIDTH   = 16;
   localparam int IM_SCAN_LENGTH = IM_ADDR_WIDTH + IM_INSTR_WIDTH + 1;

   // Scan word layout as shifted by the TAP; LSB is the write flag.
   typedef struct packed {
      logic [IM_ADDR_WIDTH-1:0]  addr;
      logic [IM_INSTR_WIDTH-1:0] data;
      logic                      we;
   } im_scan_t;

   // Loader FSM encoding; the enum view is what the debug port shows.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WRITE   = 2'd1;
   localparam logic [1:0] ST_RD_REQ  = 2'd2;
   localparam logic [1:0] ST_RD_DATA = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RD_REQ  = 2'd2,
      RD_DATA = 2'd3
   } imld_state_t;

   // I-Mem is word addressed; byte offsets other than 0 are rejected.
   function automatic logic is_word_aligned(input logic [1:0] byte_ofs);
      return byte_ofs == 2'b00;
   endfunction

endpackage

// File: rtl/as_imem_loader_if.sv
// Bundle of the loader's scan input, I-Mem port and status outputs.
// Handshake: scan_valid_i is a one-cycle strobe with no back-pressure; a word
// that arrives while the buffer is full (and not draining that cycle) is
// dropped and flagged on ovf_o. I-Mem strobes imem_we_o/imem_re_o are
// single-cycle and never overlap; imem_rdata_i is valid the cycle after
// imem_re_o.
interface as_imem_loader_if #(
   parameter int IMEM_ADDR_W = as_imem_loader_pkg::IM_ADDR_WIDTH,
   parameter int INSTR_W     = as_imem_loader_pkg::IM_INSTR_WIDTH,
   parameter int CNT_W       = as_imem_loader_pkg::IM_CNT_WIDTH
);
   import as_imem_loader_pkg::*;

   localparam int SCAN_W = IMEM_ADDR_W + INSTR_W + 1;

   logic                   scan_valid_i;
   logic [SCAN_W-1:0]      scan_word_i;
   logic                   imem_we_o;
   logic                   imem_re_o;
   logic [IMEM_ADDR_W-3:0] imem_addr_o;
   logic [INSTR_W-1:0]     imem_wdata_o;
   logic [INSTR_W-1:0]     imem_rdata_i;
   logic [SCAN_W-1:0]      capture_o;
   logic                   hold_o;
   logic                   ovf_o;
   logic                   misalign_o;
   logic [CNT_W-1:0]       wr_cnt_o;
   imld_state_t            state_dbg;

   modport master (
      output scan_valid_i, scan_word_i, imem_rdata_i,
      input  imem_we_o, imem_re_o, imem_addr_o, imem_wdata_o,
      input  capture_o, hold_o, ovf_o, misalign_o, wr_cnt_o, state_dbg
   );

   modport slave (
      input  scan_valid_i, scan_word_i, imem_rdata_i,
      output imem_we_o, imem_re_o, imem_addr_o, imem_wdata_o,
      output capture_o, hold_o, ovf_o, misalign_o, wr_cnt_o, state_dbg
   );

endinterface

// File: rtl/as_sync_fifo.sv
// Small synchronous FIFO, head visible combinationally on rdata.
// A push while full is accepted only if a pop happens in the same cycle;
// a push into an empty FIFO is never popped in that same cycle.
module as_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; reset discards all contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/as_imem_loader.sv
// Buffers TAP scan words and replays them as I-Mem writes or readbacks,
// holding the core while any command is queued or in flight.
module as_imem_loader
   import as_imem_loader_pkg::*;
#(
   parameter int IMEM_ADDR_W = IM_ADDR_WIDTH,
   parameter int INSTR_W     = IM_INSTR_WIDTH,
   parameter int FIFO_DEPTH  = IM_FIFO_DEPTH,
   parameter int CNT_W       = IM_CNT_WIDTH
) (
   input logic              clk_i,
   input logic              rst_i,
   as_imem_loader_if.slave  bus
);
   localparam int SCAN_W = IMEM_ADDR_W + INSTR_W + 1;

   logic [SCAN_W-1:0]      head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic [IMEM_ADDR_W-1:0] head_addr;
   logic [INSTR_W-1:0]     head_instr;
   logic                   head_we;

   logic [1:0]             state;
   logic [IMEM_ADDR_W-1:0] cmd_addr;
   logic [INSTR_W-1:0]     cmd_data;
   logic                   cap_pend;
   logic                   we_q;
   logic                   re_q;
   logic [IMEM_ADDR_W-3:0] addr_q;
   logic [INSTR_W-1:0]     wdata_q;
   logic [SCAN_W-1:0]      cap_q;
   logic                   hold_q;
   logic                   ovf_q;
   logic                   mis_q;
   logic [CNT_W-1:0]       cnt_q;

   assign head_addr  = head[SCAN_W-1 -: IMEM_ADDR_W];
   assign head_instr = head[INSTR_W:1];
   assign head_we    = head[0];
   assign pop        = (state == ST_IDLE) && !fifo_empty;

   as_sync_fifo #(
      .WIDTH (SCAN_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (bus.scan_valid_i),
      .pop   (pop),
      .wdata (bus.scan_word_i),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Command sequencer: pop in IDLE, then drive one registered I-Mem strobe.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         cmd_addr <= '0;
         cmd_data <= '0;
         cap_pend <= 1'b0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mis_q    <= 1'b0;
      end else begin
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         cap_pend <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  if (!is_word_aligned(head_addr[1:0])) begin
                     mis_q <= 1'b1;
                  end else begin
                     cmd_addr <= head_addr;
                     cmd_data <= head_instr;
                     state    <= head_we ? ST_WRITE : ST_RD_REQ;
                  end
               end
            end
            ST_WRITE: begin
               we_q    <= 1'b1;
               addr_q  <= cmd_addr[IMEM_ADDR_W-1:2];
               wdata_q <= cmd_data;
               state   <= ST_IDLE;
            end
            ST_RD_REQ: begin
               re_q   <= 1'b1;
               addr_q <= cmd_addr[IMEM_ADDR_W-1:2];
               state  <= ST_RD_DATA;
            end
            default: begin
               // Read data appears the cycle after the strobe; grab it next edge
               // so the sequencer can already accept the following command.
               cap_pend <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Readback register for the next Capture-DR.
   always_ff @(posedge clk_i) begin
      if (!rst_i)        cap_q <= '0;
      else if (cap_pend) cap_q <= {cmd_addr, bus.imem_rdata_i, 1'b0};
   end

   // Status: delayed busy, sticky overflow, saturating commit counter.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         hold_q <= 1'b0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hold_q <= !fifo_empty || (state != ST_IDLE);
         if (bus.scan_valid_i && fifo_full && !pop) ovf_q <= 1'b1;
         if (we_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.imem_we_o    = we_q;
   assign bus.imem_re_o    = re_q;
   assign bus.imem_addr_o  = addr_q;
   assign bus.imem_wdata_o = wdata_q;
   assign bus.capture_o    = cap_q;
   assign bus.hold_o       = hold_q;
   assign bus.ovf_o        = ovf_q;
   assign bus.misalign_o   = mis_q;
   assign bus.wr_cnt_o     = cnt_q;
   assign bus.state_dbg    = imld_state_t'(state);

endmodule

// File: doc/as_imem_loader.md
Name: as_imem_loader

Overview:
Clock-domain back end of the JTAG I-Mem load path. It accepts scan words {addr, instr, we} that the TAP delivers on Update-DR, already synchronised into clk_i, and buffers them in a small FIFO. It then writes them into the instruction memory, or reads a word back into a capture register for the next Capture-DR. While loading is in progress it asserts a hold to the core.

Parameters:
IMEM_ADDR_W, 10, I-Mem byte-address width (word index = addr[IMEM_ADDR_W-1:2])
INSTR_W, 32, instruction width
FIFO_DEPTH, 4, scan-word buffer entries (power of two, >=2)
CNT_W, 16, width of write counter

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-low
scan_valid_i  in  1  one-cycle strobe: new scan word from TAP Update-DR
scan_word_i  in  IMEM_ADDR_W+INSTR_W+1  {addr, instr, we}; LSB = we
imem_we_o  out  1  I-Mem write enable
imem_re_o  out  1  I-Mem read enable
imem_addr_o  out  IMEM_ADDR_W-2  I-Mem word index
imem_wdata_o  out  INSTR_W  I-Mem write data
imem_rdata_i  in  INSTR_W  I-Mem read data, valid one cycle after imem_re_o
capture_o  out  IMEM_ADDR_W+INSTR_W+1  readback word {addr, rdata, 0} for TAP Capture-DR
hold_o  out  1  core hold; high while loader is busy
ovf_o  out  1  sticky: scan word dropped because FIFO full
misalign_o  out  1  sticky: command with addr[1:0] != 0 discarded
wr_cnt_o  out  CNT_W  committed writes, saturating

Behaviour:
- Reset (rst_i=0 at a rising edge): FIFO empty, FSM=IDLE, all outputs 0, capture_o=0, wr_cnt_o=0.
- Push:
  - On scan_valid_i=1 the word is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and ovf_o is set.
  - Push and pop on an empty FIFO: the pushed word is not popped that cycle (no bypass).
- FSM states: IDLE, WRITE, RD_REQ, RD_DATA.
  - IDLE, FIFO non-empty: pop the head.
    - addr[1:0] != 0: set misalign_o, stay IDLE.
    - Else we=1: go to WRITE.
    - Else (we=0): go to RD_REQ.
  - WRITE: imem_we_o=1 for exactly one cycle with addr/wdata from the popped word. Increment wr_cnt_o (saturate at all-ones). Go to IDLE.
  - RD_REQ: imem_re_o=1 for one cycle. Go to RD_DATA.
  - RD_DATA: capture_o <= {addr, imem_rdata_i, 1'b0}. Go to IDLE.
- imem_addr_o/imem_wdata_o are registered and hold their last value outside WRITE/RD_REQ. imem_we_o and imem_re_o are never high simultaneously.
- Latency:
  - scan_valid_i sampled at edge k.
  - Pop at edge k+1, when the FIFO was empty and the FSM idle.
  - imem_we_o high between edges k+2 and k+3; the write commits at edge k+3.
  - For a read, capture_o is updated at edge k+4.
- Throughput: one write per 2 cycles, one read per 3 cycles. The TAP delivers at most one word per ~48 TCK, so overflow is an error condition only.
- hold_o: registered; equals (FIFO non-empty OR FSM != IDLE), delayed one cycle. It deasserts one cycle after the last command completes.
- ovf_o and misalign_o clear only on reset.
- Reset mid-operation: any in-flight write is abandoned. imem_we_o is 0 from the first cycle after the reset edge, and FIFO contents are discarded.

Decomposition:
- as_pack:
  - im_scan_length = imem_addr_width+instr_width+1
  - typedef struct packed im_scan_t {addr, data, we}
  - enum imld_state_t {IDLE, WRITE, RD_REQ, RD_DATA}
- Sub-module as_sync_fifo (parameterised width/depth; push, pop, full, empty; same sync active-low reset). Reusable elsewhere.

Test Plan:
- Push {0x000, 0x00010137, 1}, then {0x004, 0x01D00513, 1}, 4 cycles apart -> two imem_we_o pulses at word indices 0 and 1 with those data; wr_cnt_o=2; hold_o falls 1 cycle after the second write.
- Preload word 0x3FC = 0xAAAAAAAA, then push {0x3FC, X, 0} -> imem_re_o pulse at index 0xFF; capture_o = {0x3FC, 0xAAAAAAAA, 0} at edge k+4; imem_we_o stays 0.
- Five consecutive-cycle pushes with FIFO_DEPTH=4 -> all 5 accepted, because the first pop frees a slot on edge k+1. Then 6 pushes while stalled -> ovf_o=1, exactly one word lost, the remaining writes are in order.
- Push {0x006, 0x12345678, 1} -> no imem_we_o, misalign_o=1, wr_cnt_o unchanged; the next aligned write proceeds normally.
- Assert rst_i=0 the cycle the FSM enters WRITE with 2 words queued -> imem_we_o=0 from the next cycle, FIFO empty, hold_o=0, wr_cnt_o=0.
